// File: rtl/arb_out_fifo_pkg.sv
// arb_out_fifo_pkg: shared word width and default FIFO depth for the arbiter output buffer
`ifndef WORD_BITS
`define WORD_BITS 8
`endif
`ifndef ARB_FIFO_DEPTH_LOG2
`define ARB_FIFO_DEPTH_LOG2 2
`endif
package arb_out_fifo_pkg;
    localparam int lp_word_bits = `WORD_BITS;
    localparam int lp_depth_log2 = `ARB_FIFO_DEPTH_LOG2;
endpackage

// File: rtl/arb_out_fifo_if.sv
// arb_out_fifo_if: arbiter-side push stream and consumer-side valid/ready stream
// Ports (signals): snk_data/snk_valid from arbiter, src_data/src_valid/src_ready to consumer
interface arb_out_fifo_if
    import arb_out_fifo_pkg::*;
#(
    parameter int p_st_bits = lp_word_bits
);
    logic [p_st_bits-1:0] snk_data;
    logic                 snk_valid;
    logic [p_st_bits-1:0] src_data;
    logic                 src_valid;
    logic                 src_ready;
    modport slave (input snk_data, snk_valid, src_ready, output src_data, src_valid);
    modport master (output snk_data, snk_valid, src_ready, input src_data, src_valid);
endinterface

// File: rtl/arb_fifo_ram.sv
// arb_fifo_ram: register array with one synchronous write port and one asynchronous read port
// Ports: clk, i_we/i_waddr/i_wdata (write), i_raddr/o_rdata (read)
module arb_fifo_ram
    import arb_out_fifo_pkg::*;
#(
    parameter int p_st_bits = lp_word_bits,
    parameter int p_aw      = lp_depth_log2
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [p_aw-1:0]      i_waddr,
    input  logic [p_st_bits-1:0] i_wdata,
    input  logic [p_aw-1:0]      i_raddr,
    output logic [p_st_bits-1:0] o_rdata
);
    logic [p_st_bits-1:0] r_mem [1<<p_aw];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/arb_out_fifo.sv
// arb_out_fifo: show-ahead capture FIFO behind the no-backpressure arbiter, with sticky overflow flag
// Ports: clk, rst (sync active-high), bus (slave: arbiter push in, consumer valid/ready out),
//        o_full, o_empty, o_count, o_overflow, i_clr_ovf
// Optional: ARB_OUT_FIFO_BYPASS_EN forwards the input word combinationally when empty
module arb_out_fifo
    import arb_out_fifo_pkg::*;
#(
    parameter int p_st_bits    = lp_word_bits,
    parameter int p_depth_log2 = lp_depth_log2
) (
    input  logic                  clk,
    input  logic                  rst,
    arb_out_fifo_if.slave         bus,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [p_depth_log2:0] o_count,
    output logic                  o_overflow,
    input  logic                  i_clr_ovf
);
    localparam int lp_cw    = p_depth_log2 + 1;
    localparam int lp_depth = 1 << p_depth_log2;
    logic [p_depth_log2-1:0] r_wr_ptr, r_rd_ptr;
    logic [p_depth_log2:0]   r_count;
    logic                    r_overflow;
    logic [p_st_bits-1:0]    w_rdata;
    logic                    w_byp, w_pop, w_push, w_drop;
`ifdef ARB_OUT_FIFO_BYPASS_EN
    assign w_byp = o_empty & bus.snk_valid;
`else
    assign w_byp = 1'b0;
`endif
    assign o_full     = r_count == lp_cw'(lp_depth);
    assign o_empty    = r_count == '0;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign bus.src_valid = ~o_empty | w_byp;
    assign bus.src_data  = w_byp ? bus.snk_data : (o_empty ? '0 : w_rdata);
    // A bypassed word consumed in the same cycle never touches the memory.
    assign w_pop  = ~o_empty & bus.src_ready;
    assign w_push = bus.snk_valid & (~o_full | w_pop) & ~(w_byp & bus.src_ready);
    assign w_drop = bus.snk_valid & o_full & ~w_pop;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + p_depth_log2'(w_push);
            r_rd_ptr   <= r_rd_ptr + p_depth_log2'(w_pop);
            r_count    <= r_count + lp_cw'(w_push) - lp_cw'(w_pop);
            r_overflow <= w_drop | (r_overflow & ~i_clr_ovf);
        end
    end
    arb_fifo_ram #(
        .p_st_bits(p_st_bits),
        .p_aw     (p_depth_log2)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_push & ~rst),
        .i_waddr(r_wr_ptr),
        .i_wdata(bus.snk_data),
        .i_raddr(r_rd_ptr),
        .o_rdata(w_rdata)
    );
endmodule

// File: tb/tb_arb_out_fifo.sv
// tb_arb_out_fifo: directed self-checking bench for arb_out_fifo (base build)
module tb_arb_out_fifo;
    import arb_out_fifo_pkg::*;
    logic       clk = 1'b0;
    logic       rst;
    logic       full, empty, ovf, clr_ovf;
    logic [2:0] count;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] q[$];
    arb_out_fifo_if #(.p_st_bits(8)) bus ();
    arb_out_fifo #(.p_st_bits(8), .p_depth_log2(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .o_full    (full),
        .o_empty   (empty),
        .o_count   (count),
        .o_overflow(ovf),
        .i_clr_ovf (clr_ovf)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        bus.snk_valid = v;
        bus.snk_data  = d;
        bus.src_ready = r;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end
    initial begin
        logic [7:0] d;
        int         nxt, rcv;
        logic       rdy, pop, push;
        rst = 1'b1;
        clr_ovf = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", bus.src_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_data", bus.src_data, 0);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        chk("empty_ready_count", count, 0);
        // ordered pass-through with continuous ready
        for (int i = 0; i < 3; i++) begin
            d = 8'h11 * 8'(i + 1);
            drive(1'b1, d, 1'b1);
            tick();
            chk("pt_valid", bus.src_valid, 1);
            chk("pt_data", bus.src_data, d);
            chk("pt_count", count, 1);
        end
        drive(1'b0, 8'h00, 1'b1);
        tick();
        chk("pt_drained", count, 0);
        // fill, overflow, drain, clear
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 1'b0);
            tick();
            if (i == 3) begin
                chk("fill_full", full, 1);
                chk("fill_count", count, 4);
                chk("fill_ovf0", ovf, 0);
            end
        end
        chk("ovf_set", ovf, 1);
        chk("ovf_count", count, 4);
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_a", bus.src_data, 8'hA0 + 8'(i));
            tick();
        end
        chk("drain_a_empty", empty, 1);
        chk("drain_a_valid", bus.src_valid, 0);
        drive(1'b0, 8'h00, 1'b0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clear", ovf, 0);
        // full with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hB0 + 8'(i), 1'b0);
            tick();
        end
        chk("b_full", full, 1);
        drive(1'b1, 8'hB4, 1'b1);
        tick();
        chk("b_count", count, 4);
        chk("b_ovf", ovf, 0);
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 1; i < 5; i++) begin
            chk("drain_b", bus.src_data, 8'hB0 + 8'(i));
            tick();
        end
        chk("drain_b_empty", empty, 1);
        // pointer wrap: ready toggles, pushes whenever a slot is free
        nxt = 0;
        rcv = 0;
        for (int c = 0; c < 40 && rcv < 10; c++) begin
            rdy  = c[0];
            pop  = (q.size() != 0) && rdy;
            push = (nxt < 10) && (q.size() < 4 || pop);
            chk("wrap_count", count, q.size());
            if (q.size() != 0) chk("wrap_data", bus.src_data, q[0]);
            drive(push, 8'(nxt), rdy);
            tick();
            if (pop) begin
                void'(q.pop_front());
                rcv++;
            end
            if (push) begin
                q.push_back(8'(nxt));
                nxt++;
            end
        end
        chk("wrap_received", rcv, 10);
        drive(1'b0, 8'h00, 1'b0);
        chk("wrap_final_count", count, 0);
        chk("wrap_ovf", ovf, 0);
        // reset mid-operation
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hC0 + 8'(i), 1'b0);
            tick();
        end
        chk("mid_count", count, 3);
        rst = 1'b1;
        drive(1'b1, 8'hC3, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", bus.src_valid, 0);
        chk("mid_rst_data", bus.src_data, 0);
        tick();
        chk("mid_rst_hold", count, 0);
        // set wins over clear
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hD0 + 8'(i), 1'b0);
            tick();
        end
        chk("sw_ovf", ovf, 1);
        clr_ovf = 1'b1;
        drive(1'b1, 8'hD5, 1'b0);
        tick();
        chk("sw_set_wins", ovf, 1);
        chk("sw_count", count, 4);
        drive(1'b0, 8'h00, 1'b0);
        tick();
        clr_ovf = 1'b0;
        chk("sw_cleared", ovf, 0);
        chk("sw_head", bus.src_data, 8'hD0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
